// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: result-source handshake and CDB broadcast bundle for cdb_arbiter
interface cdb_arbiter_if #(
    parameter int NUM_SRC   = 3,
    parameter int ROB_IDX_W = 6,
    parameter int PREG_W    = 6,
    parameter int DATA_W    = 32
);
    localparam int SW = $clog2(NUM_SRC);
    logic [NUM_SRC-1:0]           src_valid;
    logic [NUM_SRC-1:0]           src_ready;
    logic [NUM_SRC*ROB_IDX_W-1:0] src_rob_idx;
    logic [NUM_SRC*PREG_W-1:0]    src_phys_rd;
    logic [NUM_SRC*DATA_W-1:0]    src_value;
    logic                         cdb_valid;
    logic [ROB_IDX_W-1:0]         cdb_rob_idx;
    logic [PREG_W-1:0]            cdb_phys_rd;
    logic [DATA_W-1:0]            cdb_value;
    logic [SW-1:0]                cdb_src;
    modport master (
        output src_valid, src_rob_idx, src_phys_rd, src_value,
        input  src_ready, cdb_valid, cdb_rob_idx, cdb_phys_rd, cdb_value, cdb_src
    );
    modport slave (
        input  src_valid, src_rob_idx, src_phys_rd, src_value,
        output src_ready, cdb_valid, cdb_rob_idx, cdb_phys_rd, cdb_value, cdb_src
    );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-source result FIFOs with round-robin grant onto a single CDB.
// Define CDB_OUT_REG_EN to register all CDB outputs (one extra cycle of latency).
module cdb_arbiter #(
    parameter int NUM_SRC    = 3,
    parameter int ROB_IDX_W  = 6,
    parameter int PREG_W     = 6,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 2
) (
    input logic         clk,
    input logic         reset_n,
    input logic         flush,
    cdb_arbiter_if.slave bus
);
    localparam int SW = $clog2(NUM_SRC);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = ROB_IDX_W + PREG_W + DATA_W;
    localparam logic [PW:0] FULL = (PW+1)'(FIFO_DEPTH);

    logic [EW-1:0]      head [NUM_SRC];
    logic [NUM_SRC-1:0] nonempty;
    logic [NUM_SRC-1:0] pop;
    logic [SW-1:0]      rr_ptr, grant, cand;
    logic               any;
    logic [EW-1:0]      payload;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_fifo
        logic [EW-1:0] mem [FIFO_DEPTH];
        logic [PW-1:0] wp, rp;
        logic [PW:0]   cnt;
        logic          push;
        // ready comes from the registered count only, so a full FIFO refuses even while popping
        assign bus.src_ready[i] = cnt != FULL;
        assign push = bus.src_valid[i] & bus.src_ready[i] & ~flush;
        assign nonempty[i] = cnt != '0;
        assign head[i] = mem[rp];
        always_ff @(posedge clk)
            if (push)
                mem[wp] <= {bus.src_rob_idx[i*ROB_IDX_W +: ROB_IDX_W],
                            bus.src_phys_rd[i*PREG_W +: PREG_W],
                            bus.src_value[i*DATA_W +: DATA_W]};
        always_ff @(posedge clk or negedge reset_n)
            if (!reset_n) begin
                wp  <= '0;
                rp  <= '0;
                cnt <= '0;
            end else if (flush) begin
                wp  <= '0;
                rp  <= '0;
                cnt <= '0;
            end else begin
                if (push) wp <= wp + 1'b1;
                if (pop[i]) rp <= rp + 1'b1;
                cnt <= cnt + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop[i]};
            end
    end

    always_comb begin
        any   = 1'b0;
        grant = '0;
        cand  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = SW'((int'(rr_ptr) + k) % NUM_SRC);
            if (!any && nonempty[cand]) begin
                any   = 1'b1;
                grant = cand;
            end
        end
        pop = any ? {{(NUM_SRC-1){1'b0}}, 1'b1} << grant : '0;
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) rr_ptr <= '0;
        else if (flush) rr_ptr <= '0;
        else if (any) rr_ptr <= (grant == SW'(NUM_SRC - 1)) ? '0 : grant + 1'b1;

    assign payload = any ? head[grant] : '0;

`ifdef CDB_OUT_REG_EN
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            bus.cdb_valid <= 1'b0;
            {bus.cdb_rob_idx, bus.cdb_phys_rd, bus.cdb_value} <= '0;
            bus.cdb_src <= '0;
        end else if (flush) begin
            bus.cdb_valid <= 1'b0;
            {bus.cdb_rob_idx, bus.cdb_phys_rd, bus.cdb_value} <= '0;
            bus.cdb_src <= '0;
        end else begin
            bus.cdb_valid <= any;
            {bus.cdb_rob_idx, bus.cdb_phys_rd, bus.cdb_value} <= payload;
            bus.cdb_src <= grant;
        end
`else
    assign bus.cdb_valid = any;
    assign {bus.cdb_rob_idx, bus.cdb_phys_rd, bus.cdb_value} = payload;
    assign bus.cdb_src = grant;
`endif
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed stimulus with per-source expected queues drained by a CDB monitor
module tb_cdb_arbiter;
    localparam int N = 3;
`ifdef CDB_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    logic clk = 1'b0;
    logic reset_n, flush;
    int tests = 0, fails = 0;
    int k [N];
    logic [N-1:0] acc;
    logic [43:0] exp_q [N][$];
    logic [2:0] bp_exp [5] = '{3'b111, 3'b111, 3'b001, 3'b010, 3'b100};

    cdb_arbiter_if #(.NUM_SRC(N), .ROB_IDX_W(6), .PREG_W(6), .DATA_W(32)) bus ();
    cdb_arbiter #(.NUM_SRC(N), .ROB_IDX_W(6), .PREG_W(6), .DATA_W(32), .FIFO_DEPTH(2)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int i, input logic v, input logic [5:0] r, input logic [5:0] p,
                         input logic [31:0] d);
        bus.src_valid[i] = v;
        bus.src_rob_idx[i*6 +: 6] = r;
        bus.src_phys_rd[i*6 +: 6] = p;
        bus.src_value[i*32 +: 32] = d;
    endtask

    task automatic commit(output logic [N-1:0] a);
        a = bus.src_valid & bus.src_ready & {N{~flush}};
        for (int i = 0; i < N; i++)
            if (a[i])
                exp_q[i].push_back({bus.src_rob_idx[i*6 +: 6], bus.src_phys_rd[i*6 +: 6],
                                    bus.src_value[i*32 +: 32]});
    endtask

    task automatic clear_q();
        for (int i = 0; i < N; i++) exp_q[i].delete();
    endtask

    task automatic do_flush();
        flush = 1'b1;
        clear_q();
        @(negedge clk);
        #1 flush = 1'b0;
    endtask

    task automatic idle_all();
        for (int i = 0; i < N; i++) drive(i, 1'b0, 6'd0, 6'd0, 32'd0);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && n < 40) begin
            @(negedge clk);
            #1 n++;
        end
        chk(name, 64'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 64'd0);
    endtask

    initial begin
        fork
            begin : monitor
                forever begin
                    @(negedge clk);
                    if (reset_n) begin
                        if (bus.cdb_valid) begin
                            if (int'(bus.cdb_src) >= N || exp_q[bus.cdb_src].size() == 0) begin
                                tests++;
                                fails++;
                                $display("FAIL sb_unexpected: got src %0d value 0x%0h, expected no broadcast",
                                         bus.cdb_src, bus.cdb_value);
                            end else
                                chk("sb_entry", 64'({bus.cdb_rob_idx, bus.cdb_phys_rd, bus.cdb_value}),
                                    64'(exp_q[bus.cdb_src].pop_front()));
                        end else
                            chk("idle_zero", 64'({bus.cdb_src, bus.cdb_rob_idx, bus.cdb_phys_rd, bus.cdb_value}),
                                64'd0);
                    end
                end
            end
            begin : driver
                reset_n = 1'b0;
                flush = 1'b0;
                idle_all();
                repeat (3) @(negedge clk);
                chk("rst_cdb_valid", 64'(bus.cdb_valid), 64'd0);
                #1 reset_n = 1'b1;
                @(negedge clk);
                chk("rst_ready", 64'(bus.src_ready), 64'(3'b111));
                chk("rst_payload", 64'({bus.cdb_valid, bus.cdb_src, bus.cdb_rob_idx, bus.cdb_phys_rd,
                                        bus.cdb_value}), 64'd0);
                #1;
                drive(1, 1'b1, 6'd5, 6'd12, 32'hDEADBEEF);
                commit(acc);
                chk("single_accept", 64'(acc), 64'(3'b010));
                for (int n = 1; n <= 3; n++) begin
                    @(negedge clk);
                    chk("single_valid", 64'(bus.cdb_valid), 64'(n == LAT));
                    if (n == LAT)
                        chk("single_fields", 64'({bus.cdb_src, bus.cdb_rob_idx, bus.cdb_phys_rd, bus.cdb_value}),
                            64'({2'd1, 6'd5, 6'd12, 32'hDEADBEEF}));
                    #1;
                    if (n == 1) idle_all();
                end
                drain("single_drain");
                do_flush();
                drive(0, 1'b1, 6'd1, 6'd10, 32'hA0);
                drive(1, 1'b1, 6'd2, 6'd11, 32'hB1);
                drive(2, 1'b1, 6'd3, 6'd12, 32'hC2);
                commit(acc);
                for (int n = 1; n <= LAT + 3; n++) begin
                    @(negedge clk);
                    chk("rr_valid", 64'(bus.cdb_valid), 64'(n >= LAT && n < LAT + 3));
                    if (n >= LAT && n < LAT + 3) begin
                        chk("rr_src", 64'(bus.cdb_src), 64'(n - LAT));
                        chk("rr_value", 64'(bus.cdb_value), 64'(32'hA0 + 32'h11 * (n - LAT)));
                    end
                    #1;
                    if (n == 1) idle_all();
                end
                drain("rr_drain");
                do_flush();
                for (int i = 0; i < N; i++) k[i] = 0;
                for (int c = 0; c < 15; c++) begin
                    if (c < 5) chk("bp_ready", 64'(bus.src_ready), 64'(bp_exp[c]));
                    for (int i = 0; i < N; i++)
                        drive(i, 1'b1, 6'(i * 16 + k[i]), 6'(i * 8 + k[i]), 32'((i << 16) | k[i]));
                    commit(acc);
                    for (int i = 0; i < N; i++) if (acc[i]) k[i]++;
                    @(negedge clk);
                    #1;
                end
                chk("bp_accepted", 64'(k[0] + k[1] + k[2]), 64'd19);
                idle_all();
                drain("bp_drain");
                do_flush();
                for (int c = 0; c < 8; c++) begin
                    chk("solo_ready", 64'(bus.src_ready), 64'(3'b111));
                    drive(0, 1'b1, 6'(c), 6'(c + 1), 32'h5000 + 32'(c));
                    commit(acc);
                    @(negedge clk);
                    #1;
                end
                idle_all();
                drain("solo_drain");
                do_flush();
                for (int c = 0; c < 2; c++) begin
                    for (int i = 0; i < N; i++)
                        drive(i, 1'b1, 6'(20 + 10 * c + i), 6'(30 + 10 * c + i), 32'(32'h100 * (c + 1) + i));
                    commit(acc);
                    @(negedge clk);
                    #1;
                end
                idle_all();
                flush = 1'b1;
                clear_q();
                @(negedge clk);
                chk("flush_valid", 64'(bus.cdb_valid), 64'd0);
                chk("flush_ready", 64'(bus.src_ready), 64'(3'b111));
                #1 flush = 1'b0;
                for (int n = 0; n < 4; n++) begin
                    @(negedge clk);
                    chk("post_flush_valid", 64'(bus.cdb_valid), 64'd0);
                end
                #1;
            end
        join_any
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Common data bus (CDB) arbiter for the out-of-order core. Sits between the functional units (ALU, load unit, branch unit) and the consumers of completed results. It buffers each unit's completed result in a small per-source FIFO. Each cycle it grants one non-empty source, round-robin, and broadcasts that result on the single CDB. The CDB drives reorder_buffer writeback (writeback_valid/idx/value) and issue_queue forwarding (fwd_rd/fwd_rd_val).

Parameters:
NUM_SRC, 3, number of result sources (index 0 = ALU, 1 = load, 2 = branch); legal 2..8
ROB_IDX_W, 6, ROB index width
PREG_W, 6, physical register index width
DATA_W, 32, result value width
FIFO_DEPTH, 2, entries per source FIFO; power of two, >= 2

Ports:
clk  input  1  core clock; all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
flush  input  1  synchronous pipeline flush (mispredict recovery); empties all FIFOs
src_valid  input  NUM_SRC  per-source result valid
src_ready  output  NUM_SRC  per-source FIFO can accept
src_rob_idx  input  NUM_SRC*ROB_IDX_W  flattened; source i at bits [i*ROB_IDX_W +: ROB_IDX_W]
src_phys_rd  input  NUM_SRC*PREG_W  flattened destination physical register
src_value  input  NUM_SRC*DATA_W  flattened result value
cdb_valid  output  1  broadcast valid this cycle
cdb_rob_idx  output  ROB_IDX_W  ROB entry being written back
cdb_phys_rd  output  PREG_W  physical register being produced (wakeup tag)
cdb_value  output  DATA_W  result value
cdb_src  output  clog2(NUM_SRC)  granted source index (debug / verification)

Behaviour:
- Reset (reset_n low, asynchronous):
  - all FIFOs empty; rr_ptr = 0
  - cdb_valid = 0; cdb_rob_idx, cdb_phys_rd, cdb_value and cdb_src = 0
  - src_ready = all ones once reset releases
- Reset asserted mid-operation discards all buffered results; there is no drain.
- Per-source FIFO:
  - src_ready[i] = (count[i] != FIFO_DEPTH), computed from registered count only; there is no same-cycle pop bypass.
  - A push occurs when src_valid[i] & src_ready[i]. The entry is {rob_idx, phys_rd, value}.
  - src_valid while not ready is not captured. The source must hold its result until ready.
  - Pointers wrap modulo FIFO_DEPTH. Simultaneous push and pop on a non-full, non-empty FIFO leaves count unchanged.
- Arbitration (combinational on registered FIFO state):
  - Candidates are sources with count[i] != 0.
  - Scan starts at rr_ptr and ascends with wrap. The first candidate found is granted.
  - On a grant, that FIFO head pops at the clock edge and rr_ptr <= (grant + 1) mod NUM_SRC.
  - With no candidate: cdb_valid = 0 and rr_ptr holds.
  - Exactly one broadcast per cycle maximum. Results from one source are broadcast in acceptance order.
- CDB output (base build):
  - cdb_valid and the payload are driven combinationally from the granted FIFO head.
  - Payload fields and cdb_src are forced to 0 when cdb_valid = 0.
  - Latency: a result accepted at edge t appears on the CDB in cycle t+1 at earliest.
- Starvation bound: a non-empty source is granted within NUM_SRC cycles.
- Flush:
  - flush high at an edge empties all FIFOs and resets rr_ptr to 0.
  - Pushes presented in the flush cycle are dropped.
  - cdb_valid may be 1 during the flush cycle (the broadcast is combinational). It is 0 in the following cycle.
  - Flush has priority over push and pop.
- Boundary cases:
  - All sources full and all valid: each source drains one entry per NUM_SRC cycles. Steady-state throughput is 1 result per cycle.
  - A single active source continuously valid alternates push and grant. Its throughput is 1 per cycle as long as FIFO_DEPTH >= 2.

Optional Feature:
CDB_OUT_REG_EN: when defined, all CDB outputs (cdb_valid, payload, cdb_src) are registered. A flop stage is inserted after the arbiter.
- Latency becomes 2 cycles (accepted at edge t, visible in cycle t+2).
- Output registers reset to 0 asynchronously.
- flush clears cdb_valid at the same edge, so cdb_valid = 0 in the cycle after flush.
- Undefined: outputs are combinational exactly as in the base behaviour.

Test Plan:
- Reset then idle: reset_n low 3 cycles, release -> cdb_valid = 0, all payload 0, src_ready = 3'b111.
- Single push: src 1 valid 1 cycle, rob_idx = 5, phys_rd = 12, value = 0xDEADBEEF -> next cycle cdb_valid = 1, cdb_src = 1, fields match; cycle after, cdb_valid = 0.
- Round-robin: all 3 sources push in the same cycle (values 0xA0, 0xB1, 0xC2) with rr_ptr = 0 -> broadcasts src 0, 1, 2 on 3 consecutive cycles, then cdb_valid = 0.
- Full/backpressure: src 2 valid every cycle while src 0 and 1 also stream -> src_ready[2] deasserts after 2 unbroadcast entries, no result is lost or duplicated, and per-source order is preserved (scoreboard compare).
- Flush: fill src 0 with 2 entries, assert flush for 1 cycle -> cdb_valid = 0 the next cycle, src_ready = 3'b111, and those entries never appear.
- CDB_OUT_REG_EN build: repeat the single-push test -> result appears 2 cycles after acceptance, with identical fields.
